imem_loader: RTL

Boot-time program loader sitting directly upstream of the Mips32 fetch stage. It accepts a length-prefixed byte stream and assembles big-endian 32-bit instruction words. It writes them sequentially into instruction memory at word-aligned byte addresses (PC-style, step 4). It releases the core via `core_run` only after a complete, valid image has been stored.

---
 rtl/imem_loader.sv | 100 ++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// imem_loader: length-prefixed byte stream to big-endian instruction words, releases core when image complete.
// Optional trailing XOR checksum byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int          DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic [15:0] word_count,
  output logic        core_run,
  output logic        load_err
);
  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, WRITE, CHK, DONE, ERR} state_t;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t FIN = CHK;
`else
  localparam state_t FIN = DONE;
`endif
  localparam logic [16:0] MAX_LEN = 17'(DEPTH);
  state_t state, nxt;
  logic [15:0] len, full_len, wc1;
  logic [23:0] sh;
  logic [1:0]  bcnt;
  logic        fire, restart;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif
  assign fire     = byte_valid & byte_ready;
  assign restart  = load_start & (state == IDLE || state == DONE || state == ERR);
  assign full_len = {len[15:8], byte_data};
  assign wc1      = word_count + 16'd1;
  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE, ERR: nxt = load_start ? LEN_HI : state;
      LEN_HI:          nxt = fire ? LEN_LO : state;
      LEN_LO:          nxt = !fire ? state : ({1'b0, full_len} > MAX_LEN) ? ERR : (full_len == 16'd0) ? FIN : DATA;
      DATA:            nxt = (fire && bcnt == 2'd3) ? WRITE : state;
      WRITE:           nxt = (wc1 < len) ? DATA : FIN;
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK:             nxt = !fire ? state : (byte_data == csum) ? DONE : ERR;
`endif
      default:         nxt = IDLE;
    endcase
  end
  // Flags are registered from the next state so they line up with the state they describe
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      byte_ready <= 1'b0;
      imem_we    <= 1'b0;
      core_run   <= 1'b0;
      load_err   <= 1'b0;
      imem_addr  <= BASE_ADDR;
      imem_wdata <= 32'd0;
      word_count <= 16'd0;
      len        <= 16'd0;
      sh         <= 24'd0;
      bcnt       <= 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum       <= 8'd0;
`endif
    end else begin
      state      <= nxt;
      byte_ready <= nxt == LEN_HI || nxt == LEN_LO || nxt == DATA || nxt == CHK;
      imem_we    <= nxt == WRITE;
      core_run   <= nxt == DONE;
      load_err   <= nxt == ERR;
      if (restart) begin
        word_count <= 16'd0;
        imem_addr  <= BASE_ADDR;
        bcnt       <= 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum       <= 8'd0;
`endif
      end
      if (fire && state == LEN_HI) len[15:8] <= byte_data;
      if (fire && state == LEN_LO) len[7:0] <= byte_data;
      if (fire && state == DATA) begin
        sh   <= {sh[15:0], byte_data};
        bcnt <= bcnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum <= csum ^ byte_data;
`endif
        if (bcnt == 2'd3) imem_wdata <= {sh, byte_data};
      end
      if (state == WRITE) begin
        word_count <= wc1;
        imem_addr  <= imem_addr + 32'd4;
      end
    end
  end
endmodule
